regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; next generation of the CPU datapath register file.
- Provides a configurable data width, depth and read-port count, and a hard-wired zero register.
- Synchronous reset starts a clear sweep, one entry per cycle, tracked by a small FSM with a busy flag.
- Optional same-cycle write-to-read bypass for the decode stage.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 41 ++++
 rtl/regfile_mp.sv | 91 +++++++++
 tb/tb_regfile_mp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: default register-file geometry, register address and register-file FSM state.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_NREGS  = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: entry select, optional write forwarding (REGFILE_MP_BYPASS_EN),
// then zero-register and clear-sweep masking.
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int  DATA_W   = CPU_DATA_W,
  parameter int  DEPTH    = CPU_NREGS,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic [DATA_W-1:0] mem_i [DEPTH],
  input  logic [AW-1:0]     ra_i,
  input  logic              busy_i,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd_o
);

  logic ra_is_zero;
  assign ra_is_zero = (ZERO_REG != 0) && (ra_i == '0);

  always_comb begin
    rd_o = mem_i[ra_i];
`ifdef REGFILE_MP_BYPASS_EN
    if (we_i && (wa_i == ra_i)) begin
      rd_o = wd_i;
    end
`endif
    // Masking last so the zero register and the sweep override any forwarded value.
    if (ra_is_zero || busy_i) begin
      rd_o = '0;
    end
  end

`ifndef REGFILE_MP_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{we_i, wa_i, wd_i};
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with reset-triggered clear sweep and busy flag;
// optional same-cycle write-to-read forwarding under REGFILE_MP_BYPASS_EN.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int  DATA_W   = CPU_DATA_W,
  parameter int  DEPTH    = CPU_NREGS,
  parameter int  NUM_RD   = 2,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*AW-1:0]     ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic                     busy
);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_mp: DEPTH must be a power of two in 2..256");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_nrd
    $error("regfile_mp: NUM_RD must be in 1..4");
  end

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e         state_q;
  logic [AW-1:0]     cnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            state_q <= RF_READY;
            busy_q  <= 1'b0;
          end
        end
        RF_READY: begin
        end
      endcase
    end
  end

  assign busy = busy_q;

  logic clr_en;
  logic wr_zero;
  logic wr_en;

  assign clr_en  = !rst && (state_q == RF_CLEAR);
  assign wr_zero = (ZERO_REG != 0) && (wa == '0);
  // Writes are refused while a reset edge is pending so the sweep always starts from a clean slate.
  assign wr_en   = !rst && (state_q == RF_READY) && we && !wr_zero;

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .mem_i  (mem_q),
      .ra_i   (ra[g*AW +: AW]),
      .busy_i (busy_q),
      .we_i   (we),
      .wa_i   (wa),
      .wd_i   (wd),
      .rd_o   (rd[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: sweep timing, vector table, randomized model check, parameter variants.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 32x32, three read ports, zero register on.
  logic        rst, we, busy;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [14:0] ra;
  logic [95:0] rd;

  // Small instance: 16-bit x 8, one port.
  logic        s_rst, s_we, s_busy;
  logic [2:0]  s_wa, s_ra;
  logic [15:0] s_wd, s_rd;

  // No-zero-register instance, shares rst with the main one.
  logic        n_we, n_busy;
  logic [4:0]  n_wa, n_ra;
  logic [31:0] n_wd, n_rd;

  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd), .busy(busy));

  regfile_mp #(.DATA_W(16), .DEPTH(8), .NUM_RD(1), .ZERO_REG(1)) u_small (
    .clk(clk), .rst(s_rst), .we(s_we), .wa(s_wa), .wd(s_wd), .ra(s_ra), .rd(s_rd), .busy(s_busy));

  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(1), .ZERO_REG(0)) u_nz (
    .clk(clk), .rst(rst), .we(n_we), .wa(n_wa), .wd(n_wd), .ra(n_ra), .rd(n_rd), .busy(n_busy));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] prd(input int p);
    return rd[p*32 +: 32];
  endfunction

  // Reference model: architectural register contents.
  logic [31:0] mdl [32];

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && we && (wa == a)) return wd;
    return mdl[a];
  endfunction

  // Counts negedge samples with busy high, starting at the edge where rst has just dropped.
  task automatic count_busy(input bit wr_during, output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      ra = 15'($urandom);
      we = wr_during && (n < 30);
      wa = 5'd5;
      wd = 32'hDEADBEEF;
      #1;
      for (int p = 0; p < 3; p++) chk("sweep_rd_zero", prd(p), 32'h0);
      n++;
      @(negedge clk);
    end
    we = 1'b0;
  endtask

  typedef struct {
    logic            we;
    logic [4:0]      wa;
    logic [31:0]     wd;
    logic [2:0][4:0] ra;
    logic [2:0][31:0] ex;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    s_rst = 1'b1; s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra = '0;
    n_we = 1'b0; n_wa = '0; n_wd = '0; n_ra = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h1);
    chk("reset_small_busy", {31'h0, s_busy}, 32'h1);
    chk("reset_rd0", prd(0), 32'h0);

    // Single reset pulse: sweep length and zero reads.
    rst = 1'b0;
    count_busy(1'b0, n);
    chk("sweep_len", 32'(n), 32'd32);
    for (int a = 0; a < 32; a++) begin
      ra = {5'(a), 5'(a), 5'(a)};
      #1;
      for (int p = 0; p < 3; p++) chk("post_sweep_zero", prd(p), 32'h0);
      @(negedge clk);
    end

    // Reset reasserted mid-sweep, writes attempted during CLEAR.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(1'b1, n);
    chk("midsweep_len", 32'(n), 32'd32);
    ra = {5'd5, 5'd5, 5'd5};
    #1;
    chk("clear_write_ignored", prd(0), 32'h0);

    // Vector table.
    add(1, 5'd9,  32'h2,        0, 0, 0,   0, 0, 0);
    add(1, 5'd11, 32'h4,        9, 0, 0,   32'h2, 0, 0);
    add(1, 5'd31, 32'hFFFFFFFF, 11, 9, 0,  32'h4, 32'h2, 0);
    add(0, 5'd0,  32'h0,        9, 11, 31, 32'h2, 32'h4, 32'hFFFFFFFF);
    add(1, 5'd0,  32'h12345678, 0, 0, 0,   0, 0, 0);
    add(0, 5'd0,  32'h0,        0, 0, 0,   0, 0, 0);
    add(1, 5'd7,  32'h1,        3, 31, 31, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    add(1, 5'd7,  32'hA5A5A5A5, 7, 9, 7,
        BYP ? 32'hA5A5A5A5 : 32'h1, 32'h2, BYP ? 32'hA5A5A5A5 : 32'h1);
    add(0, 5'd0,  32'h0,        7, 7, 11,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h4);
    add(1, 5'd0,  32'h55AA55AA, 0, 0, 0,   0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      ra = {tbl[i].ra[2], tbl[i].ra[1], tbl[i].ra[0]};
      #2;
      for (int p = 0; p < 3; p++) chk($sformatf("vec%0d_p%0d", i, p), prd(p), tbl[i].ex[p]);
      if (we && wa != 5'd0) mdl[wa] = wd;
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom);
      wd = $urandom;
      ra = 15'($urandom);
      if ($urandom_range(0, 3) == 0) ra[4:0] = wa;
      #2;
      for (int p = 0; p < 3; p++) chk("rand_rd", prd(p), exp_rd(ra[p*5 +: 5]));
      if (we && wa != 5'd0) mdl[wa] = wd;
    end
    @(negedge clk);
    we = 1'b0;

    // Narrow, shallow instance.
    s_rst = 1'b0;
    n = 0;
    while (s_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("small_sweep_len", 32'(n), 32'd8);
    s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hBEEF;
    @(negedge clk);
    s_we = 1'b0; s_ra = 3'd7;
    #1;
    chk("small_r7", {16'h0, s_rd}, 32'h0000BEEF);
    @(negedge clk);
    s_we = 1'b1; s_wa = 3'd0; s_wd = 16'h1234; s_ra = 3'd0;
    #1;
    chk("small_r0_bypass", {16'h0, s_rd}, 32'h0);
    @(negedge clk);
    s_we = 1'b0;
    #1;
    chk("small_r0_dropped", {16'h0, s_rd}, 32'h0);

    // Zero register disabled: r0 is an ordinary register.
    @(negedge clk);
    chk("nz_busy", {31'h0, n_busy}, 32'h0);
    n_we = 1'b1; n_wa = 5'd0; n_wd = 32'h12345678; n_ra = 5'd0;
    #1;
    chk("nz_r0_same_cycle", n_rd, BYP ? 32'h12345678 : 32'h0);
    @(negedge clk);
    n_we = 1'b0;
    #1;
    chk("nz_r0_readback", n_rd, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
